// File: rtl/branch_predict_npc_if.sv
// Fetch-side prediction and resolve-side feedback bundle for branch_predict_npc.
// The slave modport is the predictor; master is the pipeline driving it.
interface branch_predict_npc_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAT_W = 16
);
   logic [WIDTH-1:0]  fetch_pc;
   logic              pred_taken;
   logic [WIDTH-1:0]  pred_target;
   logic [WIDTH-1:0]  npc_fetch;
   logic              res_valid;
   logic [WIDTH-1:0]  res_pc;
   logic              res_is_branch;
   logic              res_is_jump;
   logic              res_taken;
   logic [WIDTH-1:0]  res_target;
   logic              res_pred_taken;
   logic [WIDTH-1:0]  res_pred_target;
   logic              mispredict;
   logic [WIDTH-1:0]  redirect_pc;
   logic [STAT_W-1:0] stat_ctrl;
   logic [STAT_W-1:0] stat_miss;

   modport slave (
      input  fetch_pc, res_valid, res_pc, res_is_branch, res_is_jump, res_taken,
             res_target, res_pred_taken, res_pred_target,
      output pred_taken, pred_target, npc_fetch, mispredict, redirect_pc,
             stat_ctrl, stat_miss
   );

   modport master (
      output fetch_pc, res_valid, res_pc, res_is_branch, res_is_jump, res_taken,
             res_target, res_pred_taken, res_pred_target,
      input  pred_taken, pred_target, npc_fetch, mispredict, redirect_pc,
             stat_ctrl, stat_miss
   );
endinterface

// File: rtl/branch_predict_npc.sv
// Direct-mapped BTB with 2-bit counters: combinational next-PC prediction at fetch,
// mispredict/redirect and table training at resolve.
module branch_predict_npc #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BTB_DEPTH = 16,
   parameter int unsigned STAT_W    = 16
) (
   input logic                 clk,
   input logic                 rst,
   branch_predict_npc_if.slave bus
);
   localparam int unsigned IDX   = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = WIDTH - IDX - 2;

   logic [BTB_DEPTH-1:0] valid_q, valid_d;
   logic [BTB_DEPTH-1:0] uncond_q, uncond_d;
   logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_d    [BTB_DEPTH];
   logic [WIDTH-1:0]     target_q [BTB_DEPTH];
   logic [WIDTH-1:0]     target_d [BTB_DEPTH];
   logic [1:0]           ctr_q    [BTB_DEPTH];
   logic [1:0]           ctr_d    [BTB_DEPTH];
   logic [STAT_W-1:0]    stat_ctrl_q, stat_ctrl_d;
   logic [STAT_W-1:0]    stat_miss_q, stat_miss_d;

   logic [IDX-1:0]   fetch_idx, res_idx;
   logic [TAG_W-1:0] fetch_tag, res_tag;
   logic             fetch_hit, res_hit;
   logic             taken_eff, upd, mispredict;

   assign fetch_idx = bus.fetch_pc[IDX+1:2];
   assign fetch_tag = bus.fetch_pc[WIDTH-1:IDX+2];
   assign res_idx   = bus.res_pc[IDX+1:2];
   assign res_tag   = bus.res_pc[WIDTH-1:IDX+2];
   assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign res_hit   = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

   always_comb begin
      bus.pred_taken  = fetch_hit && (uncond_q[fetch_idx] || ctr_q[fetch_idx][1]);
      bus.pred_target = fetch_hit ? target_q[fetch_idx] : '0;
      bus.npc_fetch   = bus.pred_taken ? bus.pred_target : bus.fetch_pc + WIDTH'(4);
   end

   assign taken_eff  = bus.res_taken || bus.res_is_jump;
   assign upd        = bus.res_valid && (bus.res_is_branch || bus.res_is_jump);
   assign mispredict = bus.res_valid &&
                       ((taken_eff != bus.res_pred_taken) ||
                        (taken_eff && (bus.res_target != bus.res_pred_target)));

   always_comb begin
      bus.mispredict  = mispredict;
      bus.redirect_pc = taken_eff ? bus.res_target : bus.res_pc + WIDTH'(4);
      bus.stat_ctrl   = stat_ctrl_q;
      bus.stat_miss   = stat_miss_q;
   end

   always_comb begin
      valid_d  = valid_q;
      uncond_d = uncond_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd) begin
         if (res_hit) begin
            // A jump flag overrides the branch flag when both are set.
            if (bus.res_is_jump) begin
               target_d[res_idx] = bus.res_target;
               uncond_d[res_idx] = 1'b1;
               ctr_d[res_idx]    = 2'd3;
            end else if (bus.res_taken) begin
               target_d[res_idx] = bus.res_target;
               if (ctr_q[res_idx] != 2'd3) ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
            end else if (ctr_q[res_idx] != 2'd0) begin
               ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
            end
         end else if (taken_eff) begin
            valid_d[res_idx]  = 1'b1;
            tag_d[res_idx]    = res_tag;
            target_d[res_idx] = bus.res_target;
            uncond_d[res_idx] = bus.res_is_jump;
            ctr_d[res_idx]    = bus.res_is_jump ? 2'd3 : 2'd2;
         end
      end else if (bus.res_valid && bus.res_pred_taken && res_hit) begin
         // Non-control instruction was predicted taken: the entry belongs to an alias.
         valid_d[res_idx] = 1'b0;
      end
   end

   always_comb begin
      stat_ctrl_d = stat_ctrl_q;
      stat_miss_d = stat_miss_q;
      if (upd && !(&stat_ctrl_q))        stat_ctrl_d = stat_ctrl_q + STAT_W'(1);
      if (mispredict && !(&stat_miss_q)) stat_miss_d = stat_miss_q + STAT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         uncond_q    <= '0;
         stat_ctrl_q <= '0;
         stat_miss_q <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         uncond_q    <= uncond_d;
         tag_q       <= tag_d;
         target_q    <= target_d;
         ctr_q       <= ctr_d;
         stat_ctrl_q <= stat_ctrl_d;
         stat_miss_q <= stat_miss_d;
      end
   end
endmodule

// File: doc/branch_predict_npc.md
BRANCH_PREDICT_NPC -- requirements
Module: branch_predict_npc

Interface
REQ-001 Parameter: WIDTH, 32, address/data width in bits.
REQ-002 Parameter: BTB_DEPTH, 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_DEPTH).
REQ-003 Parameter: STAT_W, 16, width of the statistics counters.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: fetch_pc  input  WIDTH  PC of the instruction being fetched.
REQ-007 Port: pred_taken  output  1  prediction for fetch_pc.
REQ-008 Port: pred_target  output  WIDTH  predicted target; 0 when no hit.
REQ-009 Port: npc_fetch  output  WIDTH  next fetch PC.
REQ-010 Port: res_valid  input  1  resolve-stage instruction is valid.
REQ-011 Port: res_pc  input  WIDTH  PC of the resolving instruction.
REQ-012 Port: res_is_branch  input  1  conditional branch (beq/bne/blez class).
REQ-013 Port: res_is_jump  input  1  unconditional j, jal or jr.
REQ-014 Port: res_taken  input  1  actual outcome; forced taken when res_is_jump=1.
REQ-015 Port: res_target  input  WIDTH  actual target (pc+4+offset, index or register value).
REQ-016 Port: res_pred_taken  input  1  pred_taken carried down the pipe with this instruction.
REQ-017 Port: res_pred_target  input  WIDTH  pred_target carried down the pipe.
REQ-018 Port: mispredict  output  1  flush request to the front end.
REQ-019 Port: redirect_pc  output  WIDTH  correct next PC when mispredict=1.
REQ-020 Port: stat_ctrl  output  STAT_W  count of resolved control instructions.
REQ-021 Port: stat_miss  output  STAT_W  count of mispredicts.

Function
REQ-022 Each BTB entry SHALL hold: valid, tag = pc[WIDTH-1:IDX+2], target, uncond bit, and a 2-bit saturating counter.
REQ-023 Index SHALL be pc[IDX+1:2]; hit = valid AND tag equality.
REQ-024 Prediction SHALL be combinational from fetch_pc: pred_taken = hit AND (uncond OR ctr[1]); pred_target = the entry target when hit, else 0.
REQ-025 npc_fetch SHALL be pred_target when pred_taken=1, else fetch_pc+4 (modulo 2^WIDTH).
REQ-026 taken_eff = res_taken OR res_is_jump.
REQ-027 mispredict SHALL be combinational: res_valid AND (taken_eff != res_pred_taken OR (taken_eff AND res_target != res_pred_target)).
REQ-028 redirect_pc SHALL be res_target when taken_eff=1, else res_pc+4.
REQ-029 Aliasing: res_valid with neither res_is_branch nor res_is_jump, but res_pred_taken=1, SHALL give mispredict=1 and redirect_pc=res_pc+4; if res_pc hits, that entry SHALL be invalidated at the next edge.
REQ-030 Table updates SHALL occur only on the rising clk edge when res_valid=1 and (res_is_branch OR res_is_jump).
REQ-031 Hit, branch: ctr increments (saturating at 3) if taken, else decrements (saturating at 0); target is rewritten only if taken.
REQ-032 Hit, jump: target is rewritten, uncond=1, ctr=3.
REQ-033 Miss, taken: allocate or overwrite the indexed entry with valid=1, new tag, target=res_target, uncond=res_is_jump, ctr=2 (branch) or 3 (jump).
REQ-034 Miss, not-taken branch: no allocation.
REQ-035 Read/write to the same index in the same cycle: fetch SHALL see pre-edge contents; there is no bypass.
REQ-036 res_is_branch and res_is_jump both 1 SHALL be treated as a jump.
REQ-037 stat_ctrl SHALL increment per update event (REQ-030); stat_miss SHALL increment when mispredict=1 at the edge; both saturate at all-ones.

Reset
REQ-038 rst=1 SHALL immediately clear all valid bits, counters, targets, uncond bits and both statistics counters, regardless of clk.
REQ-039 After reset: pred_taken=0, pred_target=0, npc_fetch=fetch_pc+4.
REQ-040 With rst=1, mispredict and redirect_pc SHALL still follow REQ-027/028 combinationally, and no table update SHALL occur.
REQ-041 Deassertion mid-stream: the first rising edge with rst=0 SHALL apply any pending resolve update.

Verification
REQ-042 Reset, then fetch_pc=0x40 -> pred_taken=0, npc_fetch=0x44.
REQ-043 Resolve beq at 0x40, taken, target 0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle fetch 0x40 -> pred_taken=1, pred_target=0x80 (ctr=2).
REQ-044 Same beq resolved not-taken twice -> ctr goes 2 to 1 to 0; pred_taken=0 after the first; stat_miss increments each time it was predicted taken.
REQ-045 jr at 0x100 to 0x200, then to 0x300 with res_pred_target=0x200 -> mispredict=1, redirect_pc=0x300; entry target becomes 0x300.
REQ-046 Alias: 0x40 and 0x40+4*BTB_DEPTH; allocate the first, fetch the second -> no hit; a non-branch resolving with res_pred_taken=1 -> redirect_pc=res_pc+4 and the entry is invalidated.
REQ-047 2^STAT_W+3 mispredicts -> stat_miss holds all-ones; rst asserted between edges -> outputs cleared without a clock.
